// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width and receiver state encoding.
// Used by both the RX and TX paths.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK_WAIT
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous bit.
// RST_VAL sets the reset value so an idle-high line stays high through reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid/framing-error strobes.
// A stop bit sampled low parks in BRK_WAIT until the line returns high.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state_q;
    logic [CNT_W-1:0]     clk_cnt_q;
    logic [CNT_W-1:0]     clk_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [IDX_W-1:0]     bit_idx_d;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 busy_q;
    logic                 half_hit;
    logic                 full_hit;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    assign clk_cnt_d = clk_cnt_q + CNT_W'(1);
    assign bit_idx_d = bit_idx_q + IDX_W'(1);
    assign half_hit  = (clk_cnt_q == HALF_M1);
    assign full_hit  = (clk_cnt_q == FULL_M1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                    if (!rx_s) begin
                        state_q <= START;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (half_hit) begin
                        clk_cnt_q <= '0;
                        if (!rx_s) begin
                            state_q <= DATA;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_d;
                    end
                end
                DATA: begin
                    if (full_hit) begin
                        clk_cnt_q          <= '0;
                        shreg_q[bit_idx_q] <= rx_s;
                        if (bit_idx_q == LAST_IDX) begin
                            bit_idx_q <= '0;
                            state_q   <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_d;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_d;
                    end
                end
                STOP: begin
                    // Leaving mid-stop-bit lets a back-to-back start edge be caught.
                    if (full_hit) begin
                        clk_cnt_q <= '0;
                        if (rx_s) begin
                            data_q  <= shreg_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= BRK_WAIT;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_d;
                    end
                end
                BRK_WAIT: begin
                    clk_cnt_q <= '0;
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    clk_cnt_q <= '0;
                    bit_idx_q <= '0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign data_out      = data_q;
    assign data_valid    = valid_q;
    assign framing_error = ferr_q;
    assign busy          = busy_q;

endmodule
